// File: rtl/calc_seq_ctrl.sv
// Sequential wrapper around a signed add/sub/abs ALU: one command per handshake, registered result.
// Optional CALC_ACCUM_EN adds an accumulator that can stand in for operand A.
module calc_seq_ctrl #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_r,
  output logic             out_ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
`ifdef CALC_ACCUM_EN
  ,
  input  logic             in_use_acc
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       r_q;
  logic               ovf_q, sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               load, capture;
  logic [W-1:0]       a_src;

  logic [W-1:0]       opx, opy, sum, alu_r;
  logic               do_sub, pass, alu_ovf;

`ifdef CALC_ACCUM_EN
  logic [W-1:0]       acc_q;
  assign a_src = in_use_acc ? acc_q : in_a;
`else
  assign a_src = in_a;
`endif

  // |X| is computed as 0 - X; a non-negative X is passed straight through.
  always_comb begin
    opx    = a_q;
    opy    = b_q;
    do_sub = 1'b0;
    pass   = 1'b0;
    case (op_q)
      3'b000: ;
      3'b001: do_sub = 1'b1;
      3'b010, 3'b011: begin
        opx    = '0;
        opy    = b_q;
        do_sub = 1'b1;
        pass   = ~b_q[W-1];
      end
      3'b100: begin
        opx = b_q;
        opy = a_q;
      end
      3'b101: begin
        opx    = b_q;
        opy    = a_q;
        do_sub = 1'b1;
      end
      default: begin
        opx    = '0;
        opy    = a_q;
        do_sub = 1'b1;
        pass   = ~a_q[W-1];
      end
    endcase
    sum = do_sub ? (opx - opy) : (opx + opy);
    if (pass) begin
      alu_r   = opy;
      alu_ovf = 1'b0;
    end else begin
      alu_r   = sum;
      alu_ovf = ((opx[W-1] ^ opy[W-1]) == do_sub) && (sum[W-1] != opx[W-1]);
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A capture with overflow wins over a simultaneous clear.
  assign sticky_d = (sticky_q & ~clr_sticky) | (capture & alu_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
`ifdef CALC_ACCUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      if (load) begin
        op_q <= in_op;
        a_q  <= a_src;
        b_q  <= in_b;
      end
      if (capture) begin
        r_q   <= alu_r;
        ovf_q <= alu_ovf;
        cnt_q <= cnt_q + CNT_W'(1);
`ifdef CALC_ACCUM_EN
        acc_q <= alu_r;
`endif
      end
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StHold);
  assign busy       = (state_q != StIdle);
  assign out_r      = r_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = cnt_q;

endmodule
